// File: rtl/user_input_irq_pkg.sv
// user_input_irq_pkg: register map, bus widths and
// address decode for the button/switch interrupt block.
package user_input_irq_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] REG_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] REG_MASK    = 3'd1;
  localparam logic [ADDR_W-1:0] REG_EDGE    = 3'd2;
  localparam logic [ADDR_W-1:0] REG_RISE_EN = 3'd3;
  localparam logic [ADDR_W-1:0] REG_FALL_EN = 3'd4;

  // One-hot register select; all zero for the
  // unmapped words 5..7.
  typedef struct packed {
    logic data;
    logic mask;
    logic edges;
    logic rise;
    logic fall;
  } reg_sel_t;

  function automatic reg_sel_t reg_decode(
    input logic [ADDR_W-1:0] addr
  );
    reg_sel_t s;
    s       = '0;
    s.data  = (addr == REG_DATA);
    s.mask  = (addr == REG_MASK);
    s.edges = (addr == REG_EDGE);
    s.rise  = (addr == REG_RISE_EN);
    s.fall  = (addr == REG_FALL_EN);
    return s;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: one channel -- 2-flop synchroniser
// followed by a consecutive-stable-clock debouncer.
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has disagreed with
  // the current one for DEBOUNCE_CYCLES clocks in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= RESET_LEVEL;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= s2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/user_input_irq.sv
// user_input_irq: debounced key/switch inputs with per-
// channel edge capture, masking and a level irq.
module user_input_irq
  import user_input_irq_pkg::*;
#(
  parameter int NUM_INPUTS      = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic [NUM_INPUTS-1:0] RESET_LEVEL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] user_input,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  irq
);

  localparam int N = NUM_INPUTS;

  logic [N-1:0]      stable;
  logic [N-1:0]      stable_d;
  logic [N-1:0]      mask_q;
  logic [N-1:0]      edge_q;
  logic [N-1:0]      rise_en_q;
  logic [N-1:0]      fall_en_q;
  logic [N-1:0]      wdata;
  logic [N-1:0]      edge_set;
  logic [N-1:0]      edge_clr;
  logic [DATA_W-1:0] rd_val;
  reg_sel_t          sel;

  for (genvar i = 0; i < N; i++) begin : g_ch
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[i])
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .pin  (user_input[i]),
      .level(stable[i])
    );
  end

  if (N < DATA_W) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[DATA_W-1:N];
  end

  assign sel   = reg_decode(avs_address);
  assign wdata = avs_writedata[N-1:0];

  assign edge_set =
    (stable & ~stable_d & rise_en_q) |
    (~stable & stable_d & fall_en_q);

  assign edge_clr =
    (avs_write && sel.edges) ? wdata : '0;

  // Previous debounced level; equal at reset so no
  // edge appears on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= RESET_LEVEL;
    end else begin
      stable_d <= stable;
    end
  end

  // Software-owned control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (avs_write) begin
      if (sel.mask) mask_q    <= wdata;
      if (sel.rise) rise_en_q <= wdata;
      if (sel.fall) fall_en_q <= wdata;
    end
  end

  // Sticky edge capture; a new edge beats a
  // same-cycle write-one-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | edge_set;
    end
  end

  // Registered level interrupt from masked edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_q & mask_q);
    end
  end

  // Zero-extended read mux; unmapped words read 0.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel.data:  rd_val[N-1:0] = stable;
      sel.mask:  rd_val[N-1:0] = mask_q;
      sel.edges: rd_val[N-1:0] = edge_q;
      sel.rise:  rd_val[N-1:0] = rise_en_q;
      sel.fall:  rd_val[N-1:0] = fall_en_q;
      default:   rd_val = '0;
    endcase
  end

  // One-cycle read latency; data holds until the
  // next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_user_input_irq.sv
// tb_user_input_irq: vector table, directed corner
// sequences and random traffic against a cycle model.
module tb_user_input_irq;

  localparam int NI  = 6;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] ui;
  logic [2:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          irq;

  int n_chk  = 0;
  int n_fail = 0;

  user_input_irq #(
    .NUM_INPUTS     (NI),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_LEVEL    (6'h00)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .user_input   (ui),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Reference model. Each channel counts how many clocks
  // in a row the pin (seen two clocks late) has disagreed
  // with the accepted level; DEB in a row flips it.
  logic [NI-1:0] m_p1, m_p2;
  logic [NI-1:0] m_lvl, m_lvl_prev;
  logic [NI-1:0] m_mask, m_edge, m_ren, m_fen;
  logic [31:0]   m_rd;
  logic          m_irq;
  int            m_run [NI];

  function automatic logic [31:0] m_read(
    input logic [2:0] a
  );
    logic [31:0] v;
    v = 32'd0;
    case (a)
      3'd0: v[NI-1:0] = m_lvl;
      3'd1: v[NI-1:0] = m_mask;
      3'd2: v[NI-1:0] = m_edge;
      3'd3: v[NI-1:0] = m_ren;
      3'd4: v[NI-1:0] = m_fen;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p1       <= '0;
      m_p2       <= '0;
      m_lvl      <= '0;
      m_lvl_prev <= '0;
      m_mask     <= '0;
      m_edge     <= '0;
      m_ren      <= '0;
      m_fen      <= '0;
      m_rd       <= '0;
      m_irq      <= 1'b0;
      for (int i = 0; i < NI; i++) m_run[i] <= 0;
    end else begin
      m_p1 <= ui;
      m_p2 <= m_p1;
      for (int i = 0; i < NI; i++) begin
        if (m_p2[i] == m_lvl[i]) begin
          m_run[i] <= 0;
        end else if (m_run[i] + 1 == DEB) begin
          m_run[i] <= 0;
          m_lvl[i] <= m_p2[i];
        end else begin
          m_run[i] <= m_run[i] + 1;
        end
      end
      m_lvl_prev <= m_lvl;
      m_edge <=
        (m_edge & ~((avs_write && avs_address == 3'd2)
                    ? avs_writedata[NI-1:0] : '0)) |
        (m_lvl & ~m_lvl_prev & m_ren) |
        (~m_lvl & m_lvl_prev & m_fen);
      m_irq <= |(m_edge & m_mask);
      if (avs_read) m_rd <= m_read(avs_address);
      if (avs_write) begin
        if (avs_address == 3'd1)
          m_mask <= avs_writedata[NI-1:0];
        if (avs_address == 3'd3)
          m_ren <= avs_writedata[NI-1:0];
        if (avs_address == 3'd4)
          m_fen <= avs_writedata[NI-1:0];
      end
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check("model irq", {31'd0, irq}, {31'd0, m_irq});
    check("model rdata", avs_readdata, m_rd);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] d);
    avs_write     = 1'b1;
    avs_address   = a;
    avs_writedata = d;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic rdchk(input string nm,
                       input logic [2:0] a,
                       input logic [31:0] exp);
    avs_read    = 1'b1;
    avs_address = a;
    cyc();
    avs_read = 1'b0;
    check(nm, avs_readdata, exp);
  endtask

  typedef struct {
    bit        wr;
    bit [2:0]  a;
    bit [31:0] d;
    bit [31:0] e;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  initial begin
    tbl = '{
      '{1'b0, 3'd0, 32'h0,        32'h0},
      '{1'b0, 3'd1, 32'h0,        32'h0},
      '{1'b0, 3'd2, 32'h0,        32'h0},
      '{1'b0, 3'd3, 32'h0,        32'h0},
      '{1'b0, 3'd4, 32'h0,        32'h0},
      '{1'b1, 3'd1, 32'hFFFFFFFF, 32'h0},
      '{1'b0, 3'd1, 32'h0,        32'h3F},
      '{1'b1, 3'd0, 32'h3F,       32'h0},
      '{1'b0, 3'd0, 32'h0,        32'h0},
      '{1'b1, 3'd3, 32'hAA,       32'h0},
      '{1'b0, 3'd3, 32'h0,        32'h2A},
      '{1'b1, 3'd6, 32'hFF,       32'h0},
      '{1'b0, 3'd6, 32'h0,        32'h0},
      '{1'b0, 3'd7, 32'h0,        32'h0},
      '{1'b1, 3'd4, 32'h15,       32'h0},
      '{1'b0, 3'd4, 32'h0,        32'h15}
    };

    rst           = 1'b1;
    ui            = '0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset irq", {31'd0, irq}, 32'd0);
    check("reset rdata", avs_readdata, 32'd0);
    rst = 1'b0;
    idle(2);

    // Register access table.
    for (int k = 0; k < NV; k++) begin
      if (tbl[k].wr) begin
        wr(tbl[k].a, tbl[k].d);
      end else begin
        rdchk($sformatf("vec%0d", k),
              tbl[k].a, tbl[k].e);
      end
    end
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h0);
    wr(3'd4, 32'h0);

    // Clean press on channel 0.
    wr(3'd3, 32'h1);
    wr(3'd1, 32'h1);
    ui[0]       = 1'b1;
    avs_read    = 1'b1;
    avs_address = 3'd0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (n == 6) begin
        check("press data early", avs_readdata, 32'h0);
        check("press irq early", {31'd0, irq}, 32'd0);
      end
      if (n == 7) begin
        check("press data", avs_readdata, 32'h1);
        check("press irq pre", {31'd0, irq}, 32'd0);
        avs_address = 3'd2;
      end
      if (n == 8) begin
        check("press edge", avs_readdata, 32'h1);
        check("press irq", {31'd0, irq}, 32'd1);
      end
    end
    avs_read = 1'b0;

    // W1C on the same clock as a new rise on bit 0.
    ui[0] = 1'b0;
    idle(10);
    ui[0] = 1'b1;
    idle(6);
    avs_write     = 1'b1;
    avs_address   = 3'd2;
    avs_writedata = 32'h1;
    cyc();
    avs_write = 1'b0;
    check("race irq0", {31'd0, irq}, 32'd1);
    cyc();
    check("race irq1", {31'd0, irq}, 32'd1);
    rdchk("race edge", 3'd2, 32'h1);
    wr(3'd2, 32'h1);
    check("clr irq same", {31'd0, irq}, 32'd1);
    cyc();
    check("clr irq drop", {31'd0, irq}, 32'd0);
    rdchk("clr edge", 3'd2, 32'h0);

    // Glitch rejection on channel 3.
    ui[0] = 1'b0;
    idle(10);
    wr(3'd3, 32'h3F);
    wr(3'd1, 32'h3F);
    ui[3] = 1'b1;
    idle(3);
    ui[3] = 1'b0;
    idle(10);
    rdchk("glitch data", 3'd0, 32'h0);
    rdchk("glitch edge", 3'd2, 32'h0);
    check("glitch irq", {31'd0, irq}, 32'd0);
    ui[3] = 1'b1;
    idle(4);
    ui[3] = 1'b0;
    idle(12);
    rdchk("pulse4 edge", 3'd2, 32'h8);
    check("pulse4 irq", {31'd0, irq}, 32'd1);
    wr(3'd2, 32'h3F);
    idle(2);

    // Falling-edge-only capture on channel 5.
    wr(3'd3, 32'h0);
    wr(3'd4, 32'h20);
    ui[5] = 1'b1;
    idle(10);
    rdchk("fall up data", 3'd0, 32'h20);
    rdchk("fall up edge", 3'd2, 32'h0);
    ui[5]       = 1'b0;
    avs_read    = 1'b1;
    avs_address = 3'd2;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (n == 7)
        check("fall edge early", avs_readdata, 32'h0);
      if (n == 8) begin
        check("fall edge", avs_readdata, 32'h20);
        check("fall irq", {31'd0, irq}, 32'd1);
      end
    end
    avs_read = 1'b0;
    wr(3'd4, 32'h0);
    rdchk("fall en off keeps", 3'd2, 32'h20);
    wr(3'd2, 32'h20);
    idle(2);

    // Masked pending edge, then unmask.
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h4);
    ui[2] = 1'b1;
    idle(10);
    check("masked irq", {31'd0, irq}, 32'd0);
    rdchk("masked edge", 3'd2, 32'h4);
    wr(3'd1, 32'h4);
    check("unmask same", {31'd0, irq}, 32'd0);
    cyc();
    check("unmask irq", {31'd0, irq}, 32'd1);
    wr(3'd1, 32'hFFFFFFC4);
    rdchk("mask hi bits", 3'd1, 32'h4);
    rdchk("addr6", 3'd6, 32'h0);

    // Reset in the middle of a debounce.
    ui = 6'h02;
    idle(4);
    rst = 1'b1;
    #1;
    check("rst irq", {31'd0, irq}, 32'd0);
    check("rst rdata", avs_readdata, 32'd0);
    ui = '0;
    idle(2);
    rst = 1'b0;
    rdchk("rst data", 3'd0, 32'h0);
    wr(3'd3, 32'h3F);
    wr(3'd4, 32'h3F);
    wr(3'd1, 32'h3F);
    idle(10);
    rdchk("rst no edge", 3'd2, 32'h0);
    check("rst no irq", {31'd0, irq}, 32'd0);

    // Random pins and bus traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NI; i++)
        if ($urandom_range(0, 7) == 0) ui[i] = ~ui[i];
      case ($urandom_range(0, 9))
        0: begin
          avs_write     = 1'b1;
          avs_address   = 3'($urandom_range(0, 7));
          avs_writedata = $urandom;
        end
        1, 2, 3: begin
          avs_read    = 1'b1;
          avs_address = 3'($urandom_range(0, 7));
        end
        default: ;
      endcase
      cyc();
      avs_write = 1'b0;
      avs_read  = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
